// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies a 2-FF-synchronized lock, releases sys_rst, faults on repeated timeouts.
// Latency: lock seen 2 edges after sampling; no backpressure, all outputs decoded from registered state only.
module pll_lock_sequencer #(
   parameter int RST_CYCLES         = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int MAX_ATTEMPTS       = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [7:0] relock_count,
   output logic [2:0] state
);

   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
   localparam int CW        = $clog2(CNT_MAX + 1);
   localparam int AW        = $clog2(MAX_ATTEMPTS + 1);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] att_q, att_d;
   logic [AW-1:0] att_inc;
   logic [7:0]    relock_q, relock_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          locked_s;

   assign locked_s = sync2_q;
   assign att_inc  = att_q + AW'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      att_d    = att_q;
      relock_d = relock_q;
      sync1_d  = pll_locked;
      sync2_d  = sync1_q;

      case (state_q)
         S_RESET_PLL: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(RST_CYCLES - 1)) begin
               state_d = S_WAIT_LOCK;
            end
         end
         S_WAIT_LOCK: begin
            cnt_d = cnt_q + CW'(1);
            // Lock takes priority over a timeout landing on the same edge.
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               att_d   = att_inc;
               state_d = (att_inc == AW'(MAX_ATTEMPTS)) ? S_FAULT : S_RESET_PLL;
            end
         end
         S_STABLE: begin
            cnt_d = cnt_q + CW'(1);
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
            end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = S_RUN;
               att_d   = '0;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d = S_RESET_PLL;
               if (relock_q != 8'hFF) begin
                  relock_d = relock_q + 8'd1;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_RESET_PLL;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q  <= S_RESET_PLL;
         cnt_q    <= '0;
         att_q    <= '0;
         relock_q <= '0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         att_q    <= att_d;
         relock_q <= relock_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
      end
   end

   assign pll_rst      = (state_q == S_RESET_PLL) || (state_q == S_FAULT);
   assign sys_rst      = (state_q != S_RUN);
   assign fault        = (state_q == S_FAULT);
   assign ready        = ~sys_rst & ~fault;
   assign relock_count = relock_q;
   assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues expected outputs per edge, a negedge monitor pops and compares.
module tb_pll_lock_sequencer;

   localparam int RC  = 4;
   localparam int LSC = 8;
   localparam int LTO = 32;
   localparam int MA  = 2;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_rst, ready, fault;
   logic [7:0] relock_count;
   logic [2:0] state;

   pll_lock_sequencer #(
      .RST_CYCLES(RC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT(LTO), .MAX_ATTEMPTS(MA)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
      .relock_count(relock_count), .state(state)
   );

   always #10 refclk = ~refclk;

   int cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic [7:0] rc;
      string      tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // {pll_rst, sys_rst, ready, fault} implied by a debug state code
   function automatic logic [3:0] flags(input logic [2:0] st);
      flags = {(st == 3'd0 || st == 3'd4), (st != 3'd3), (st == 3'd3), (st == 3'd4)};
   endfunction

   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         n_tests++;
         if (mon_e.cyc != cyc ||
             {state, pll_rst, sys_rst, ready, fault, relock_count} != {mon_e.st, flags(mon_e.st), mon_e.rc}) begin
            n_fail++;
            $display("FAIL %s (edge %0d, checked at %0d): got state=%0d pll_rst=%b sys_rst=%b ready=%b fault=%b relock=%0d, required state=%0d flags(pll_rst,sys_rst,ready,fault)=%b relock=%0d",
                     mon_e.tag, mon_e.cyc, cyc, state, pll_rst, sys_rst, ready, fault, relock_count,
                     mon_e.st, flags(mon_e.st), mon_e.rc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic expect_at(input int n, input logic [2:0] st, input logic [7:0] rc, input string tag);
      exp_t e;
      e.cyc = cyc + n;
      e.st  = st;
      e.rc  = rc;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // One-edge reset; afterwards the current edge is "E0" and rst is low for the next edge.
   task automatic do_reset(input logic lk, input string tag);
      rst        = 1'b1;
      pll_locked = lk;
      tick(1);
      expect_at(0, 3'd0, 8'd0, tag);
      rst = 1'b0;
   endtask

   initial begin : stim
      int rc_model;

      tick(2);

      // Timeout to fault with lock held low
      do_reset(1'b0, "reset_values");
      expect_at(1, 3'd0, 8'd0, "pll_rst_pulse1_e1");
      expect_at(3, 3'd0, 8'd0, "pll_rst_pulse1_e3");
      expect_at(4, 3'd1, 8'd0, "pll_rst_release_e4");
      expect_at(35, 3'd1, 8'd0, "wait_before_timeout1");
      expect_at(36, 3'd0, 8'd0, "timeout1_reset_pll");
      expect_at(39, 3'd0, 8'd0, "pll_rst_pulse2_e3");
      expect_at(40, 3'd1, 8'd0, "wait_lock2");
      expect_at(71, 3'd1, 8'd0, "wait_before_timeout2");
      expect_at(72, 3'd4, 8'd0, "fault_entered");
      tick(72);
      pll_locked = 1'b1;
      expect_at(6, 3'd4, 8'd0, "fault_sticky_with_lock");
      tick(6);

      // rst clears fault; lock glitch during STABLE
      do_reset(1'b1, "rst_clears_fault");
      expect_at(4, 3'd1, 8'd0, "wait_lock_held_high");
      expect_at(5, 3'd2, 8'd0, "stable_enter");
      tick(9);
      expect_at(2, 3'd2, 8'd0, "stable_before_glitch");
      expect_at(3, 3'd1, 8'd0, "glitch_to_wait");
      expect_at(5, 3'd1, 8'd0, "glitch_wait_hold");
      expect_at(6, 3'd2, 8'd0, "requalify_start");
      expect_at(13, 3'd2, 8'd0, "requalify_full_8");
      expect_at(14, 3'd3, 8'd0, "run_after_glitch");
      pll_locked = 1'b0;
      tick(3);
      pll_locked = 1'b1;
      tick(11);

      // Lock loss in RUN, one timeout, relock, then loss again: attempts must have cleared
      pll_locked = 1'b0;
      expect_at(2, 3'd3, 8'd0, "loss_run_edge2");
      expect_at(3, 3'd0, 8'd1, "loss_reset_edge3");
      expect_at(7, 3'd1, 8'd1, "loss_wait_lock");
      expect_at(38, 3'd1, 8'd1, "loss_wait_before_to");
      expect_at(39, 3'd0, 8'd1, "loss_timeout1");
      expect_at(43, 3'd1, 8'd1, "loss_wait_lock2");
      tick(43);
      pll_locked = 1'b1;
      expect_at(2, 3'd1, 8'd1, "relock_sync_delay");
      expect_at(3, 3'd2, 8'd1, "relock_stable");
      expect_at(10, 3'd2, 8'd1, "relock_stable_last");
      expect_at(11, 3'd3, 8'd1, "relock_run");
      tick(11);
      pll_locked = 1'b0;
      expect_at(3, 3'd0, 8'd2, "loss2_reset");
      expect_at(7, 3'd1, 8'd2, "loss2_wait");
      expect_at(39, 3'd0, 8'd2, "attempts_cleared");
      expect_at(43, 3'd1, 8'd2, "loss2_wait2");
      expect_at(74, 3'd1, 8'd2, "loss2_wait2_last");
      expect_at(75, 3'd4, 8'd2, "fault_after_loss");
      tick(75);

      // Power-up lock: raise lock 10 cycles after release
      do_reset(1'b0, "rst_from_fault");
      expect_at(3, 3'd0, 8'd0, "pu_pll_rst_e3");
      expect_at(4, 3'd1, 8'd0, "pu_pll_rst_low_e4");
      tick(10);
      pll_locked = 1'b1;
      expect_at(2, 3'd1, 8'd0, "pu_sync_delay");
      expect_at(3, 3'd2, 8'd0, "pu_stable");
      expect_at(10, 3'd2, 8'd0, "pu_sys_rst_still_high");
      expect_at(11, 3'd3, 8'd0, "pu_run_10_after_sample");
      tick(11);

      // relock_count saturation
      rc_model = 0;
      for (int i = 1; i <= 260; i++) begin
         if (rc_model < 255) rc_model++;
         pll_locked = 1'b0;
         expect_at(3, 3'd0, 8'(rc_model), "sat_loss");
         tick(3);
         pll_locked = 1'b1;
         expect_at(13, 3'd3, 8'(rc_model), "sat_run");
         tick(13);
      end

      // Reset in RUN, then in the middle of STABLE
      do_reset(1'b1, "rst_in_run");
      expect_at(4, 3'd1, 8'd0, "after_run_rst_wait");
      expect_at(5, 3'd2, 8'd0, "after_run_rst_stable");
      tick(7);
      do_reset(1'b1, "rst_in_stable");
      expect_at(3, 3'd0, 8'd0, "restart_pll_rst");
      expect_at(4, 3'd1, 8'd0, "restart_wait");
      expect_at(5, 3'd2, 8'd0, "restart_stable");
      expect_at(12, 3'd2, 8'd0, "restart_stable_last");
      expect_at(13, 3'd3, 8'd0, "restart_run");
      tick(15);

      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations unchecked, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the board PLL, clocked from the free-running 50 MHz reference. It drives the PLL's `rst` and qualifies its `locked` flag. It releases a synchronous reset to the 125 MHz datapath only after lock has been stable for a programmable time. Lock loss is handled by re-resetting the PLL, and repeated lock timeouts end in a sticky fault.

## Interface

**Parameters**
- `RST_CYCLES`, default 16: `pll_rst` pulse width in refclk cycles; must be ≥ 1.
- `LOCK_STABLE_CYCLES`, default 1024: continuous synchronized-lock cycles required before release; must be ≥ 1.
- `LOCK_TIMEOUT`, default 65536: cycles allowed in WAIT_LOCK before an attempt fails; must be ≥ 1.
- `MAX_ATTEMPTS`, default 3: failed lock attempts that trigger FAULT; must be ≥ 1.

**Ports**
- `refclk` in 1: the single clock, 50 MHz reference.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: raw `locked` from the PLL, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL, high = PLL held in reset.
- `sys_rst` out 1: reset for downstream logic, high until lock is qualified.
- `ready` out 1: high while in RUN; always equal to `~sys_rst & ~fault`.
- `fault` out 1: sticky; set after `MAX_ATTEMPTS` lock timeouts.
- `relock_count` out 8: number of RUN→RESET_PLL lock-loss events, saturating at 255.
- `state` out 3: FSM state for debug: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT.

## Operation

**Input synchronizer**
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`. Only `locked_s` is used by the FSM.

**Internals and output decode**
- One shared cycle counter, cleared on every state transition.
- One attempt counter of width clog2(MAX_ATTEMPTS+1).
- All outputs are decoded from registered state and registered counters only. There is no combinational path from `pll_locked` to any output.
- `pll_rst = (state==RESET_PLL || state==FAULT)`.
- `sys_rst = (state != RUN)`.

**RESET_PLL**
- Counter increments each cycle.
- When counter == RST_CYCLES-1: go to WAIT_LOCK.

**WAIT_LOCK**
- If `locked_s` = 1: go to STABLE.
- Else, when counter == LOCK_TIMEOUT-1: increment attempts.
  - If the new attempts value == MAX_ATTEMPTS: go to FAULT.
  - Otherwise: go to RESET_PLL.
- If lock and timeout occur in the same cycle, lock wins.

**STABLE**
- If `locked_s` = 0: go to WAIT_LOCK. The timeout restarts from 0 and attempts are unchanged.
- Else, when counter == LOCK_STABLE_CYCLES-1: go to RUN and clear attempts.

**RUN**
- If `locked_s` = 0: go to RESET_PLL and increment `relock_count`, saturating at 255.

**FAULT**
- Terminal. Holds `pll_rst` = 1, `sys_rst` = 1, `fault` = 1.
- Exit is only via `rst`.

**Reset (`rst`)**
- State goes to RESET_PLL.
- Counters, attempts and `relock_count` go to 0; synchronizer flops go to 0.
- `rst` has priority in every state, including mid-count and FAULT.

## Timing

**Output values during and after `rst`**
- `pll_rst` = 1, `sys_rst` = 1, `ready` = 0, `fault` = 0, `relock_count` = 0, `state` = 0.
- After `rst` falls, `pll_rst` stays high for exactly RST_CYCLES more edges.

**Lock acquisition**
- `pll_locked` is first sampled high at edge t.
- `locked_s` is high after edge t+1.
- The FSM enters STABLE at edge t+2.
- RUN is entered, and `sys_rst` falls, at edge t+2+LOCK_STABLE_CYCLES.

**Lock loss in RUN**
- `pll_locked` is first sampled low at edge t.
- RESET_PLL is entered at edge t+2, so `sys_rst` and `pll_rst` rise 3 edges after the drop.
- `relock_count` updates on the same edge.

**Pulse-width filtering**
- A `pll_locked` low pulse shorter than one refclk period can be missed; this is acceptable.
- Any low of 2 or more cycles is guaranteed to be seen.

**Timeout and fault timing**
- One failed attempt costs RST_CYCLES + LOCK_TIMEOUT cycles.
- FAULT is entered on the edge where the final timeout is reached.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, MAX_ATTEMPTS=2.

- **Power-up lock:** release `rst`, then raise `pll_locked` 10 cycles later. Required: `pll_rst` high for exactly 4 cycles after release; `sys_rst` falls and `ready` rises exactly 10 edges after `pll_locked` is first sampled high; `state` = 3.
- **Lock glitch in STABLE:** drop `pll_locked` for 3 cycles, 4 cycles into STABLE. Required: return to WAIT_LOCK with `pll_rst` staying low; the full 8-cycle qualification restarts after lock returns; `relock_count` stays 0.
- **Lock loss in RUN:** drop `pll_locked` while in RUN. Required: `sys_rst` = 1 and `pll_rst` = 1 on the 3rd edge after the drop; `relock_count` = 1; the next lock returns to RUN and attempts are cleared.
- **Timeout to fault:** hold `pll_locked` = 0. Required: two 4-cycle `pll_rst` pulses separated by 32 cycles; `fault` = 1, `pll_rst` = 1, `state` = 4 on edge 4+32+4+32 after reset release; later raising `pll_locked` has no effect; `rst` clears the fault.
- **Counter saturation:** force 260 RUN→loss cycles. Required: `relock_count` stops at 255.
- **Reset mid-operation:** assert `rst` for 1 cycle in the middle of STABLE and again in RUN. Required: all outputs return to their reset values on the next edge, and the sequence restarts from RESET_PLL.
